// File: rtl/fft_pkg.sv
// fft_pkg: shared defaults, complex sample type and bit-reversal helper for the FFT front end
package fft_pkg;
   localparam int LOG2N_DEF  = 3;
   localparam int DATA_W_DEF = 16;
   typedef struct packed {
      logic signed [DATA_W_DEF-1:0] re;
      logic signed [DATA_W_DEF-1:0] im;
   } cplx_t;
   function automatic int bitrev(input int idx, input int log2n);
      int r = 0;
      for (int i = 0; i < log2n; i++) r = (r << 1) | ((idx >> i) & 1);
      return r;
   endfunction
endpackage

// File: rtl/fft_bitrev_buffer_if.sv
// fft_bitrev_buffer_if: natural-order sample stream in, butterfly operand pair stream out
interface fft_bitrev_buffer_if #(parameter int DATA_W = 16);
   logic                     in_valid, in_ready;
   logic signed [DATA_W-1:0] xin, yin;
   logic                     out_valid, out_ready, out_last;
   logic signed [DATA_W-1:0] xout1, yout1, xout2, yout2;
   modport master (output in_valid, xin, yin, out_ready,
                   input  in_ready, out_valid, out_last, xout1, yout1, xout2, yout2);
   modport slave  (input  in_valid, xin, yin, out_ready,
                   output in_ready, out_valid, out_last, xout1, yout1, xout2, yout2);
endinterface

// File: rtl/fft_pingpong_ram.sv
// fft_pingpong_ram: two banks of N complex words, one write port and two async read ports
module fft_pingpong_ram #(
   parameter int LOG2N  = 3,
   parameter int DATA_W = 16
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic                  wbank,
   input  logic [LOG2N-1:0]      waddr,
   input  logic [2*DATA_W-1:0]   wdata,
   input  logic                  rbank,
   input  logic [LOG2N-1:0]      raddr0,
   input  logic [LOG2N-1:0]      raddr1,
   output logic [2*DATA_W-1:0]   rdata0,
   output logic [2*DATA_W-1:0]   rdata1
);
   logic [2*DATA_W-1:0] mem [2][2**LOG2N];
   always_ff @(posedge clk)
      if (we) mem[wbank][waddr] <= wdata;
   assign rdata0 = mem[rbank][raddr0];
   assign rdata1 = mem[rbank][raddr1];
endmodule

// File: rtl/fft_bitrev_buffer.sv
// fft_bitrev_buffer: ping-pong reorder buffer feeding radix-2 DIT butterflies in bit-reversed pairs
module fft_bitrev_buffer
   import fft_pkg::*;
#(
   parameter int LOG2N  = LOG2N_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input logic             clk,
   input logic             rst_n,
   fft_bitrev_buffer_if.slave bus
);
   logic                wr_sel, rd_sel;
   logic [LOG2N-1:0]    wr_cnt, a0, a1;
   logic [LOG2N-2:0]    rd_cnt;
   logic [1:0]          full;
   logic [2*DATA_W-1:0] d0, d1;
   logic                acc, adv, ld, wr_end, rd_last;
   assign bus.in_ready = !full[wr_sel];
   assign acc     = bus.in_valid && bus.in_ready;
   assign adv     = !bus.out_valid || bus.out_ready;
   assign ld      = adv && full[rd_sel];
   assign wr_end  = &wr_cnt;
   assign rd_last = &rd_cnt;
   always_comb begin
      a0 = LOG2N'(bitrev(32'({rd_cnt, 1'b0}), LOG2N));
      a1 = LOG2N'(bitrev(32'({rd_cnt, 1'b1}), LOG2N));
   end
   fft_pingpong_ram #(.LOG2N(LOG2N), .DATA_W(DATA_W)) u_ram (
      .clk(clk), .we(acc), .wbank(wr_sel), .waddr(wr_cnt), .wdata({bus.xin, bus.yin}),
      .rbank(rd_sel), .raddr0(a0), .raddr1(a1), .rdata0(d0), .rdata1(d1)
   );
   // full set and clear on one edge always hit different banks, so both land
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_sel        <= 1'b0;
         rd_sel        <= 1'b0;
         wr_cnt        <= '0;
         rd_cnt        <= '0;
         full          <= '0;
         bus.out_valid <= 1'b0;
         bus.out_last  <= 1'b0;
         bus.xout1     <= '0;
         bus.yout1     <= '0;
         bus.xout2     <= '0;
         bus.yout2     <= '0;
      end else begin
         if (acc) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_end) begin
               full[wr_sel] <= 1'b1;
               wr_sel       <= !wr_sel;
            end
         end
         if (ld) begin
            {bus.xout1, bus.yout1} <= d0;
            {bus.xout2, bus.yout2} <= d1;
            bus.out_valid          <= 1'b1;
            bus.out_last           <= rd_last;
            rd_cnt                 <= rd_cnt + 1'b1;
            if (rd_last) begin
               full[rd_sel] <= 1'b0;
               rd_sel       <= !rd_sel;
            end
         end else if (adv) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
         end
      end
endmodule

// File: tb/tb_fft_bitrev_buffer.sv
// tb_fft_bitrev_buffer: directed stimulus with a scoreboard of expected bit-reversed pairs
module tb_fft_bitrev_buffer;
   logic clk = 1'b0, rst_n = 1'b0;
   int vectors = 0, miscompares = 0, stalls = 0, popped = 0, wcnt = 0;
   logic [31:0] frm [8];
   logic [64:0] sb [$];
   int ord [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
   fft_bitrev_buffer_if #(.DATA_W(16)) b();
   fft_bitrev_buffer #(.LOG2N(3), .DATA_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
   always #5 clk = !clk;
   task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask
   always @(negedge clk) begin
      if (!rst_n) begin
         wcnt = 0;
         sb.delete();
      end else begin
         if (b.in_valid && b.in_ready) begin
            frm[wcnt] = {b.xin, b.yin};
            wcnt++;
            if (wcnt == 8) begin
               for (int j = 0; j < 4; j++)
                  sb.push_back({j == 3, frm[ord[2*j]], frm[ord[2*j+1]]});
               wcnt = 0;
            end
         end
         if (b.out_valid && b.out_ready) begin
            popped++;
            if (sb.size() == 0) chk("unexpected_pair", 72'(b.xout1), 72'hdead);
            else chk("pair", 72'({b.out_last, b.xout1, b.yout1, b.xout2, b.yout2}), 72'(sb.pop_front()));
         end
      end
   end
   task automatic put(input int x, input int y);
      int n = 0;
      b.in_valid = 1'b1;
      b.xin = 16'(x);
      b.yin = 16'(y);
      @(negedge clk);
      while (!b.in_ready && n < 500) begin
         stalls++;
         n++;
         @(negedge clk);
      end
      if (n >= 500) chk("in_ready_timeout", 72'(n), 72'(0));
      @(posedge clk);
      #1;
   endtask
   task automatic drain();
      int n = 0;
      b.in_valid = 1'b0;
      while ((sb.size() != 0 || b.out_valid) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drain_done", 72'(n < 300), 72'(1));
      @(posedge clk);
      #1;
   endtask
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   initial begin
      int p0;
      b.in_valid = 1'b0;
      b.xin = '0;
      b.yin = '0;
      b.out_ready = 1'b1;
      cyc(3);
      @(negedge clk);
      chk("rst_out_valid", 72'(b.out_valid), 72'(0));
      chk("rst_out_last", 72'(b.out_last), 72'(0));
      chk("rst_outs", 72'({b.xout1, b.yout1, b.xout2, b.yout2}), 72'(0));
      chk("rst_in_ready", 72'(b.in_ready), 72'(1));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(1);
      for (int k = 0; k < 8; k++) put(k, -k);
      b.in_valid = 1'b0;
      chk("lat_not_yet", 72'(b.out_valid), 72'(0));
      cyc(1);
      chk("lat_valid", 72'(b.out_valid), 72'(1));
      chk("lat_pair0", 72'({b.xout1, b.xout2, b.out_last}), 72'({16'd0, 16'd4, 1'b0}));
      drain();
      stalls = 0;
      p0 = popped;
      for (int f = 0; f < 3; f++)
         for (int k = 0; k < 8; k++) put(20 * f + k, 1000 + k);
      drain();
      chk("b2b_no_stall", 72'(stalls), 72'(0));
      chk("b2b_pairs", 72'(popped - p0), 72'(12));
      b.out_ready = 1'b0;
      for (int k = 0; k < 16; k++) put(100 + k, -100 - k);
      b.in_valid = 1'b0;
      @(negedge clk);
      chk("stall_in_ready", 72'(b.in_ready), 72'(0));
      chk("stall_pair0", 72'({b.out_valid, b.xout1, b.yout1, b.xout2, b.yout2}),
          72'({1'b1, 16'd100, -16'sd100, 16'd104, -16'sd104}));
      cyc(4);
      @(negedge clk);
      chk("stall_frozen", 72'({b.out_valid, b.xout1, b.yout1, b.xout2, b.yout2}),
          72'({1'b1, 16'd100, -16'sd100, 16'd104, -16'sd104}));
      chk("stall_in_ready2", 72'(b.in_ready), 72'(0));
      p0 = popped;
      @(posedge clk);
      #1;
      b.out_ready = 1'b1;
      drain();
      chk("stall_pairs", 72'(popped - p0), 72'(8));
      for (int k = 0; k < 5; k++) put(50 + k, 7);
      b.in_valid = 1'b0;
      rst_n = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_idle", 72'({b.out_valid, b.in_ready}), 72'({1'b0, 1'b1}));
      @(posedge clk);
      #1;
      p0 = popped;
      for (int k = 0; k < 8; k++) begin
         put(10 + k, -10 - k);
         if (k < 7) chk("no_early_out", 72'(b.out_valid), 72'(0));
      end
      drain();
      chk("post_rst_pairs", 72'(popped - p0), 72'(4));
      for (int k = 0; k < 8; k++)
         if (k % 2 == 0) put(-32768, 32767);
         else put(32767, -32768);
      drain();
      chk("sb_empty", 72'(sb.size()), 72'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
